// File: rtl/sub_bytes_seq_pkg.sv
// Shared AES definitions for the iterative SubBytes stage: sizes, FSM encoding
// and the byte-slot helper used to walk the state MSB byte first.
package sub_bytes_seq_pkg;

    localparam int STATE_W  = 128;
    localparam int BYTE_W   = 8;
    localparam int NB_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Byte slot handled by S-box lane `lane` on pass `chunk`; pass 0 starts at byte 15.
    function automatic logic [3:0] byte_idx(input int chunk, input int lane, input int bpc);
        return 4'(NB_BYTES - 1 - chunk * bpc - lane);
    endfunction

endpackage

// File: rtl/sub_bytes_seq_sbox.sv
// aes_sbox: combinational FIPS-197 S-box lookup (8-bit in, 8-bit out).
// The inverse table and the inv select exist only when SUB_BYTES_INV_EN is defined.
module aes_sbox
    import sub_bytes_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] din,
`ifdef SUB_BYTES_INV_EN
    input  logic              inv,
`endif
    output logic [BYTE_W-1:0] dout
);

    // Entry 0 sits in the leftmost byte of each table.
    localparam logic [0:255][BYTE_W-1:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SUB_BYTES_INV_EN
    localparam logic [0:255][BYTE_W-1:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    always_comb begin
        dout = inv ? INV[din] : FWD[din];
    end
`else
    always_comb begin
        dout = FWD[din];
    end
`endif

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: BYTES_PER_CYCLE shared S-boxes walk the 128-bit state
// MSB byte first, result offered with valid/ready. Optional inverse via SUB_BYTES_INV_EN.
module sub_bytes_seq
    import sub_bytes_seq_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
`ifdef SUB_BYTES_INV_EN
    input  logic               inv,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
        $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int K     = NB_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

    fsm_t                            state;
    fsm_t                            state_nxt;
    logic [CNT_W-1:0]                cnt;
    logic [NB_BYTES-1:0][BYTE_W-1:0] work;
    logic [BYTE_W-1:0]               sb_in  [BYTES_PER_CYCLE];
    logic [BYTE_W-1:0]               sb_out [BYTES_PER_CYCLE];
`ifdef SUB_BYTES_INV_EN
    logic                            inv_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)         state_nxt = SUB;
            SUB:     if (cnt == CNT_LAST)  state_nxt = DONE;
            DONE:    if (out_ready)        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == SUB) || (state == DONE);
        state_out = work;
    end

    // Select the bytes for the current pass; lane 0 takes the most significant one.
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sb_in[j] = work[byte_idx(int'(cnt), j, BYTES_PER_CYCLE)];
        end
    end

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
        aes_sbox u_sbox (
            .din (sb_in[j]),
`ifdef SUB_BYTES_INV_EN
            .inv (inv_r),
`endif
            .dout(sb_out[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            work  <= '0;
`ifdef SUB_BYTES_INV_EN
            inv_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= state_in;
                        cnt   <= '0;
`ifdef SUB_BYTES_INV_EN
                        inv_r <= inv;
`endif
                    end
                end
                SUB: begin
                    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                        work[byte_idx(int'(cnt), j, BYTES_PER_CYCLE)] <= sb_out[j];
                    end
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Iterative AES SubBytes stage. It sits directly upstream of the shiftRows stage and feeds it.
- Accepts a 128-bit state and substitutes BYTES_PER_CYCLE bytes per clock through shared S-box instances.
- Presents the substituted state with a valid/ready handshake.
- Trades latency for area: 4 S-boxes instead of 16 by default.

Parameters:
- BYTES_PER_CYCLE, 4: S-box instances / bytes substituted per cycle. Legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream offers state_in
- in_ready  out  1  block can accept a state
- state_in  in  128  input state; byte 15 = state_in[127:120], byte 0 = state_in[7:0]
- out_valid  out  1  state_out holds a completed result
- out_ready  in  1  downstream (shiftRows path) accepts state_out
- state_out  out  128  substituted state, same byte ordering as state_in
- busy  out  1  high in SUB or DONE

Behaviour:
- Clocking and reset:
  - Single clock domain. rst is synchronous, active-high.
  - On a reset edge: FSM goes to IDLE, byte counter cnt goes to 0, work register goes to 0.
  - Values after reset: in_ready=1, out_valid=0, busy=0, state_out=0.
- Output derivation:
  - in_ready = (fsm==IDLE), combinational from the FSM register.
  - out_valid = (fsm==DONE).
  - state_out = work register, always driven. It is meaningful only while out_valid=1.
- Constant: K = 16/BYTES_PER_CYCLE.
- IDLE:
  - If in_valid && in_ready at an edge: load work <= state_in, cnt <= 0, go to SUB.
  - Otherwise remain in IDLE.
- SUB:
  - Each cycle, replace bytes [15-cnt*B .. 16-(cnt+1)*B] of work with their S-box images, where B = BYTES_PER_CYCLE. Processing runs MSB byte first.
  - Then cnt <= cnt+1.
  - On the cycle where cnt==K-1: write the final bytes, cnt <= 0, go to DONE.
  - in_valid is ignored while in SUB.
- DONE:
  - Hold work and keep out_valid=1 until out_ready=1 at an edge.
  - At that edge, go to IDLE.
  - Acceptance of a new input happens one cycle later at the earliest. Throughput is one state per K+2 cycles.
- Latency: input accepted at edge 0 → out_valid first high in the cycle after edge K (K=4 for the default).
- cnt width is clog2(K), minimum 1 bit. It wraps only via the explicit reset to 0 on leaving SUB.
- Boundary cases:
  - out_ready held high continuously: DONE still lasts exactly one cycle.
  - out_ready asserted while out_valid=0: no effect.
  - rst asserted in any state, including mid-SUB or in DONE with out_ready=1: reset wins. The partial result is discarded and out_valid drops at that edge.
  - state_in changes after acceptance: no effect on the result.

Optional Feature:
- Macro: SUB_BYTES_INV_EN.
- Defined:
  - Adds port inv (in, 1) and an inverse S-box table per instance.
  - inv is sampled with state_in at acceptance and held for the whole operation.
  - inv=1 applies InvSubBytes.
- Undefined:
  - No inv port and no inverse table; forward S-box only.
  - Timing is identical in both builds.

Decomposition:
- Shared AES defs package holds:
  - STATE_W=128, BYTE_W=8, NB_BYTES=16
  - FSM state typedef/encoding: IDLE=0, SUB=1, DONE=2
  - helper function for byte-slice index
- Sub-module aes_sbox:
  - 8-bit in → 8-bit out combinational FIPS-197 lookup, with the inverse table under SUB_BYTES_INV_EN.
  - Instantiated BYTES_PER_CYCLE times. This is the natural and only sub-module.

Test Plan:
- Reset then all-zero input, out_ready=1 → state_out=0x63636363636363636363636363636363, with out_valid high exactly K=4 cycles after the acceptance edge.
- FIPS-197 App. B round-1 input 0x193de3bea0f4e22b9ac68d2ae9f84808 → 0xd42711aee0bf98f1b8b45de51e415230.
- out_ready held low for 10 cycles in DONE → out_valid and state_out stable and in_ready=0 throughout. Then out_ready=1 → in_ready=1 the following cycle.
- in_valid=1 with new data while in SUB → ignored. The first result is unchanged and the second input is accepted only after returning to IDLE.
- rst pulsed at SUB cycle 2 → next cycle in_ready=1, out_valid=0, state_out=0. A subsequent input of all 0xff bytes → 0x1616…16.
- With SUB_BYTES_INV_EN and inv=1, input 0x6363…63 → 0x0000…00. Input 0xd42711aee0bf98f1b8b45de51e415230 → 0x193de3bea0f4e22b9ac68d2ae9f84808.
